// File: rtl/dispense_sequencer.sv
// Timed recipe sequencer: latches a beverage recipe on Start and opens the
// dispensing valves one stage at a time (BASE -> ADIT -> SABOR -> FIN), each
// stage timed in seconds derived from an internal prescaler on CLK.
module dispense_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int T_BASE   = 5,
  parameter int T_ADIT   = 3,
  parameter int T_SABOR  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Start,
  input  logic       Abort,
  input  logic [1:0] Base,
  input  logic [1:0] Aditivo,
  input  logic       Vainilla,
  output logic       ValvCafe,
  output logic       ValvTe,
  output logic       ValvLeche,
  output logic       ValvAgua,
  output logic       ValvVainilla,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [2:0] Estado
);

  localparam int T_MAX0 = (T_BASE > T_ADIT) ? T_BASE : T_ADIT;
  localparam int T_MAX  = (T_MAX0 > T_SABOR) ? T_MAX0 : T_SABOR;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW     = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_MAX    = SW'(T_MAX);
  localparam logic [SW-1:0] BASE_LAST  = SW'((T_BASE  > 0) ? T_BASE  - 1 : 0);
  localparam logic [SW-1:0] ADIT_LAST  = SW'((T_ADIT  > 0) ? T_ADIT  - 1 : 0);
  localparam logic [SW-1:0] SABOR_LAST = SW'((T_SABOR > 0) ? T_SABOR - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BASE  = 3'd1,
    S_ADIT  = 3'd2,
    S_SABOR = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   sec_q, sec_d;
  logic [1:0]      base_q, base_d;
  logic [1:0]      adit_q, adit_d;
  logic            vain_q, vain_d;
  logic [4:0]      valves_q, valves_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            prescWrap;

  // Stage that follows BASE: additive if one was chosen and timed, else
  // vanilla if chosen and timed, else straight to FIN.
  function automatic state_t afterBase(input logic [1:0] adit, input logic vain);
    state_t nxt;
    nxt = S_FIN;
    if (vain && (T_SABOR > 0)) nxt = S_SABOR;
    if (((adit == 2'd1) || (adit == 2'd2)) && (T_ADIT > 0)) nxt = S_ADIT;
    return nxt;
  endfunction

  // Stage that follows ADIT: vanilla if chosen and timed, else FIN.
  function automatic state_t afterAdit(input logic vain);
    state_t nxt;
    nxt = S_FIN;
    if (vain && (T_SABOR > 0)) nxt = S_SABOR;
    return nxt;
  endfunction

  // Next-state, recipe latch, stage timers and registered valve/pulse values.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    adit_d    = adit_q;
    vain_d    = vain_q;
    error_d   = 1'b0;
    presc_d   = '0;
    sec_d     = '0;
    valves_d  = 5'b00000;
    prescWrap = (presc_q == PRESC_LAST);

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          if ((Base == 2'd1) || (Base == 2'd2)) begin
            base_d  = Base;
            adit_d  = Aditivo;
            vain_d  = Vainilla;
            state_d = (T_BASE > 0) ? S_BASE : afterBase(Aditivo, Vainilla);
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_BASE: begin
        if (Abort) state_d = S_IDLE;
        else if (prescWrap && (sec_q == BASE_LAST)) state_d = afterBase(adit_q, vain_q);
      end
      S_ADIT: begin
        if (Abort) state_d = S_IDLE;
        else if (prescWrap && (sec_q == ADIT_LAST)) state_d = afterAdit(vain_q);
      end
      S_SABOR: begin
        if (Abort) state_d = S_IDLE;
        else if (prescWrap && (sec_q == SABOR_LAST)) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_d == state_q) &&
        ((state_q == S_BASE) || (state_q == S_ADIT) || (state_q == S_SABOR))) begin
      presc_d = prescWrap ? '0 : presc_q + 1'b1;
      sec_d   = (prescWrap && (sec_q != SEC_MAX)) ? sec_q + 1'b1 : sec_q;
    end

    case (state_d)
      S_BASE:  valves_d = {base_d == 2'd1, base_d == 2'd2, 3'b000};
      S_ADIT:  valves_d = {2'b00, adit_d == 2'd1, adit_d == 2'd2, 1'b0};
      S_SABOR: valves_d = 5'b00001;
      default: valves_d = 5'b00000;
    endcase

    done_d = (state_d == S_FIN);
  end

  // State, counters, latched recipe and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      sec_q    <= '0;
      base_q   <= '0;
      adit_q   <= '0;
      vain_q   <= 1'b0;
      valves_q <= 5'b00000;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      base_q   <= base_d;
      adit_q   <= adit_d;
      vain_q   <= vain_d;
      valves_q <= valves_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign {ValvCafe, ValvTe, ValvLeche, ValvAgua, ValvVainilla} = valves_q;
  assign Busy   = (state_q != S_IDLE);
  assign Done   = done_q;
  assign Error  = error_q;
  assign Estado = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Testbench for dispense_sequencer: drives directed and random recipes and
// compares every cycle against a per-cycle expectation queue built from the
// recipe rules.
module tb_dispense_sequencer;

  localparam int DIV = 2;
  localparam int TBS = 3;
  localparam int TAD = 2;
  localparam int TSA = 1;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       Start, Abort, Vainilla;
  logic [1:0] Base, Aditivo;
  logic       ValvCafe, ValvTe, ValvLeche, ValvAgua, ValvVainilla;
  logic       Busy, Done, Error;
  logic [2:0] Estado;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct packed {
    logic [2:0] estado;
    logic [4:0] valves;
    logic       busy;
    logic       done;
    logic       error;
  } obs_t;

  obs_t expQ[$];

  dispense_sequencer #(
    .TICK_DIV(DIV), .T_BASE(TBS), .T_ADIT(TAD), .T_SABOR(TSA)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Abort(Abort),
    .Base(Base), .Aditivo(Aditivo), .Vainilla(Vainilla),
    .ValvCafe(ValvCafe), .ValvTe(ValvTe), .ValvLeche(ValvLeche),
    .ValvAgua(ValvAgua), .ValvVainilla(ValvVainilla),
    .Busy(Busy), .Done(Done), .Error(Error), .Estado(Estado)
  );

  // Free-running system clock.
  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    obs_t o;
    o.estado = Estado;
    o.valves = {ValvCafe, ValvTe, ValvLeche, ValvAgua, ValvVainilla};
    o.busy   = Busy;
    o.done   = Done;
    o.error  = Error;
    return o;
  endfunction

  function automatic obs_t mk(input int st, input logic [4:0] v, input logic d, input logic e);
    obs_t o;
    o.estado = 3'(st);
    o.valves = v;
    o.busy   = (st != 0);
    o.done   = d;
    o.error  = e;
    return o;
  endfunction

  // Reference: one entry per clock cycle of the recipe, seconds * DIV cycles per stage.
  task automatic buildExpect(input logic [1:0] b, input logic [1:0] a, input logic v);
    expQ.delete();
    if ((b == 2'd1) || (b == 2'd2)) begin
      for (int i = 0; i < TBS * DIV; i++)
        expQ.push_back(mk(1, (b == 2'd1) ? 5'b10000 : 5'b01000, 1'b0, 1'b0));
      if ((a == 2'd1) || (a == 2'd2))
        for (int i = 0; i < TAD * DIV; i++)
          expQ.push_back(mk(2, (a == 2'd1) ? 5'b00100 : 5'b00010, 1'b0, 1'b0));
      if (v)
        for (int i = 0; i < TSA * DIV; i++)
          expQ.push_back(mk(3, 5'b00001, 1'b0, 1'b0));
      expQ.push_back(mk(4, 5'b00000, 1'b1, 1'b0));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one recipe from Start, with optional input noise, abort, restart or reset injection.
  task automatic runRecipe(input string name, input logic [1:0] b, input logic [1:0] a,
                           input logic v, input bit noisy, input int abortAt,
                           input int restartAt, input int resetAt);
    obs_t got;
    obs_t idle;
    idle = mk(0, 5'b00000, 1'b0, 1'b0);
    buildExpect(b, a, v);
    Abort = 1'b0; Start = 1'b1; Base = b; Aditivo = a; Vainilla = v;
    tick();
    Start = 1'b0;
    if (expQ.size() == 0) begin
      got = observe();
      nChecks++;
      if (got !== mk(0, 5'b00000, 1'b0, 1'b1))
        $display("[TB] FAIL %s error_pulse: got %h expected %h", name, got, mk(0, 5'b00000, 1'b0, 1'b1));
      else nPass++;
      tick();
      got = observe();
      nChecks++;
      if (got !== idle) $display("[TB] FAIL %s error_clear: got %h expected %h", name, got, idle);
      else nPass++;
      return;
    end
    for (int i = 0; i < expQ.size(); i++) begin
      got = observe();
      nChecks++;
      if (got !== expQ[i])
        $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, i, got, expQ[i]);
      else nPass++;
      if (i == abortAt) begin
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        got = observe();
        nChecks++;
        if (got !== idle) $display("[TB] FAIL %s abort: got %h expected %h", name, got, idle);
        else nPass++;
        return;
      end
      if (i == resetAt) begin
        #2 RESET = 1'b0;
        #1;
        got = observe();
        nChecks++;
        if (got !== idle) $display("[TB] FAIL %s async_reset: got %h expected %h", name, got, idle);
        else nPass++;
        #2 RESET = 1'b1;
        return;
      end
      if (i == restartAt) begin
        Start = 1'b1; Base = 2'd2; Aditivo = 2'd1; Vainilla = 1'b1;
      end else if (noisy) begin
        Start = 1'($urandom); Base = 2'($urandom); Aditivo = 2'($urandom); Vainilla = 1'($urandom);
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    Start = 1'b0;
    got = observe();
    nChecks++;
    if (got !== idle) $display("[TB] FAIL %s back_to_idle: got %h expected %h", name, got, idle);
    else nPass++;
  endtask

  task automatic test_reset();
    obs_t got;
    got = observe();
    nChecks++;
    if (got !== mk(0, 5'b00000, 1'b0, 1'b0))
      $display("[TB] FAIL reset_state: got %h expected %h", got, mk(0, 5'b00000, 1'b0, 1'b0));
    else nPass++;
  endtask

  task automatic test_full_recipe();
    runRecipe("cafe_leche_vainilla", 2'd1, 2'd1, 1'b1, 1'b0, -1, -1, -1);
  endtask

  task automatic test_base_only();
    runRecipe("te_only", 2'd2, 2'd0, 1'b0, 1'b0, -1, -1, -1);
    runRecipe("te_aditivo3", 2'd2, 2'd3, 1'b1, 1'b0, -1, -1, -1);
  endtask

  task automatic test_invalid_base();
    runRecipe("base0", 2'd0, 2'd1, 1'b1, 1'b0, -1, -1, -1);
    runRecipe("base3", 2'd3, 2'd2, 1'b0, 1'b0, -1, -1, -1);
  endtask

  task automatic test_abort();
    runRecipe("abort_agua", 2'd1, 2'd2, 1'b1, 1'b0, TBS * DIV + 1, -1, -1);
    tick();
    runRecipe("after_abort", 2'd1, 2'd2, 1'b1, 1'b0, -1, -1, -1);
  endtask

  task automatic test_abort_in_idle();
    obs_t got;
    for (int k = 0; k < 4; k++) begin
      Start = 1'b1; Abort = 1'b1; Base = 2'(k); Aditivo = 2'd1; Vainilla = 1'b1;
      tick();
      Start = 1'b0; Abort = 1'b0;
      got = observe();
      nChecks++;
      if (got !== mk(0, 5'b00000, 1'b0, 1'b0))
        $display("[TB] FAIL abort_idle base=%0d: got %h expected %h", k, got, mk(0, 5'b00000, 1'b0, 1'b0));
      else nPass++;
    end
  endtask

  task automatic test_start_ignored();
    runRecipe("restart_mid_base", 2'd1, 2'd0, 1'b0, 1'b0, -1, 2, -1);
  endtask

  task automatic test_back_to_back();
    logic [1:0] b, a;
    logic v;
    for (int n = 0; n < 12; n++) begin
      b = 2'($urandom_range(3, 0));
      a = 2'($urandom_range(3, 0));
      v = 1'($urandom);
      runRecipe("random", b, a, v, 1'b1, -1, -1, -1);
    end
  endtask

  task automatic test_reset_mid_sabor();
    obs_t got;
    runRecipe("reset_sabor", 2'd1, 2'd0, 1'b1, 1'b0, -1, -1, TBS * DIV);
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = observe();
      nChecks++;
      if (got !== mk(0, 5'b00000, 1'b0, 1'b0))
        $display("[TB] FAIL post_reset_idle: got %h expected %h", got, mk(0, 5'b00000, 1'b0, 1'b0));
      else nPass++;
    end
    runRecipe("after_reset", 2'd2, 2'd2, 1'b1, 1'b0, -1, -1, -1);
  endtask

  // Test sequence.
  initial begin
    RESET = 1'b0; Start = 1'b0; Abort = 1'b0;
    Base = 2'd0; Aditivo = 2'd0; Vainilla = 1'b0;
    #12;
    test_reset();
    RESET = 1'b1;
    tick();
    test_reset();
    test_full_recipe();
    test_base_only();
    test_invalid_base();
    test_abort();
    test_abort_in_idle();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_sabor();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
